// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout,
// redirect FSM states and forwarding select encoding.
package pipe_hazard_ctrl_pkg;

   localparam int NREG  = 32;
   localparam int AGE_W = 2;
   localparam int RA_W  = $clog2(NREG);

   // age: 0 = writer in E, 1 = in M, 2 = in W
   typedef struct packed {
      logic             valid;
      logic             is_load;
      logic [AGE_W-1:0] age;
   } sb_entry_t;

   typedef enum logic {
      HZ_RUN,
      HZ_DRAIN
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_M  = 2'd1,
      FWD_W  = 2'd2
   } fwd_sel_t;

   // Select is captured at issue and used one stage later, when the writer has moved on.
   function automatic fwd_sel_t fwd_from_age(input sb_entry_t e);
      fwd_sel_t sel;
      sel = FWD_RF;
      if (e.valid) begin
         if (e.age == AGE_W'(0))      sel = FWD_M;
         else if (e.age == AGE_W'(1)) sel = FWD_W;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder/bus-status inputs and stall/flush/forwarding outputs of the hazard controller.
interface pipe_hazard_ctrl_if;
   import pipe_hazard_ctrl_pkg::*;

   logic            d_valid;
   logic [RA_W-1:0] d_ra1;
   logic [RA_W-1:0] d_ra2;
   logic            d_ra1En;
   logic            d_ra2En;
   logic [RA_W-1:0] d_wa;
   logic            d_RegWEn;
   logic            d_is_load;
   logic            e_redirect;
   logic            ibus_pending;
   logic            ibus_resp;
   logic            dbus_wait;

   logic            stall_f;
   logic            stall_d;
   logic            stall_e;
   logic            stall_m;
   logic            bubble_e;
   logic            bubble_w;
   logic            flush_d;
   logic            drop_fetch;
   logic [1:0]      fwd_a;
   logic [1:0]      fwd_b;

   modport master (
      output d_valid, d_ra1, d_ra2, d_ra1En, d_ra2En, d_wa, d_RegWEn, d_is_load,
             e_redirect, ibus_pending, ibus_resp, dbus_wait,
      input  stall_f, stall_d, stall_e, stall_m, bubble_e, bubble_w, flush_d,
             drop_fetch, fwd_a, fwd_b
   );

   modport slave (
      input  d_valid, d_ra1, d_ra2, d_ra1En, d_ra2En, d_wa, d_RegWEn, d_is_load,
             e_redirect, ibus_pending, ibus_resp, dbus_wait,
      output stall_f, stall_d, stall_e, stall_m, bubble_e, bubble_w, flush_d,
             drop_fetch, fwd_a, fwd_b
   );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register record of the youngest in-flight writer, aged one stage per advancing cycle.
module hazard_scoreboard
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            adv,
   input  logic            set_en,
   input  logic [RA_W-1:0] set_wa,
   input  logic            set_load,
   input  logic [RA_W-1:0] rd_a1,
   input  logic [RA_W-1:0] rd_a2,
   output sb_entry_t       rd_e1,
   output sb_entry_t       rd_e2
);

   sb_entry_t sb_q [NREG];
   sb_entry_t sb_d [NREG];

   always_comb begin
      sb_d = sb_q;
      if (adv) begin
         for (int r = 0; r < NREG; r++) begin
            if (sb_q[r].valid) begin
               if (sb_q[r].age == AGE_W'(2)) sb_d[r] = '0;
               else                          sb_d[r].age = sb_q[r].age + 1'b1;
            end
         end
         // Applied after aging so a new writer replaces any older one for the same register.
         if (set_en && set_wa != '0) begin
            sb_d[set_wa].valid   = 1'b1;
            sb_d[set_wa].is_load = set_load;
            sb_d[set_wa].age     = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) sb_q[r] <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   assign rd_e1 = sb_q[rd_a1];
   assign rd_e2 = sb_q[rd_a2];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: redirect drain FSM, load-use and forwarding.
//   state    | meaning
//   HZ_RUN   | normal flow; redirects and load-use handled in the cycle they appear
//   HZ_DRAIN | wrong-path fetch still outstanding; D flushed until its response is dropped
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave hz
);

   hz_state_t state_q, state_d;
   fwd_sel_t  fwd_a_q, fwd_a_d;
   fwd_sel_t  fwd_b_q, fwd_b_d;
   sb_entry_t src1, src2;
   logic      adv, issue, luse, hit1, hit2;
   logic      stall_f, stall_d, stall_e, stall_m;
   logic      bubble_e, bubble_w, flush_d, drop_fetch;

   assign adv   = !hz.dbus_wait;
   assign hit1  = hz.d_ra1En && hz.d_ra1 != '0 && src1.valid && src1.is_load && src1.age == '0;
   assign hit2  = hz.d_ra2En && hz.d_ra2 != '0 && src2.valid && src2.is_load && src2.age == '0;
   assign luse  = hz.d_valid && (hit1 || hit2);
   assign issue = hz.d_valid && !stall_d && !flush_d && adv;

   hazard_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .adv      (adv),
      .set_en   (issue && hz.d_RegWEn),
      .set_wa   (hz.d_wa),
      .set_load (hz.d_is_load),
      .rd_a1    (hz.d_ra1),
      .rd_a2    (hz.d_ra2),
      .rd_e1    (src1),
      .rd_e2    (src2)
   );

   always_comb begin
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      stall_m    = 1'b0;
      bubble_e   = 1'b0;
      bubble_w   = 1'b0;
      flush_d    = 1'b0;
      drop_fetch = 1'b0;
      state_d    = state_q;
      // The wrong-path response can land while M is stalled, so draining ignores dbus_wait.
      if (state_q == HZ_DRAIN) begin
         flush_d    = 1'b1;
         drop_fetch = hz.ibus_resp;
         if (hz.ibus_resp) state_d = HZ_RUN;
      end
      if (hz.dbus_wait) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         stall_e  = 1'b1;
         stall_m  = 1'b1;
         bubble_w = 1'b1;
      end else if (state_q == HZ_RUN) begin
         if (hz.e_redirect) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
            if (hz.ibus_pending && !hz.ibus_resp) state_d = HZ_DRAIN;
         end else if (luse) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
         end
      end
   end

   always_comb begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (adv) begin
         fwd_a_d = FWD_RF;
         fwd_b_d = FWD_RF;
         if (issue) begin
            if (hz.d_ra1 != '0) fwd_a_d = fwd_from_age(src1);
            if (hz.d_ra2 != '0) fwd_b_d = fwd_from_age(src2);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HZ_RUN;
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         state_q <= state_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign hz.stall_f    = reset & stall_f;
   assign hz.stall_d    = reset & stall_d;
   assign hz.stall_e    = reset & stall_e;
   assign hz.stall_m    = reset & stall_m;
   assign hz.bubble_e   = reset & bubble_e;
   assign hz.bubble_w   = reset & bubble_w;
   assign hz.flush_d    = reset & flush_d;
   assign hz.drop_fetch = reset & drop_fetch;
   assign hz.fwd_a      = fwd_a_q;
   assign hz.fwd_b      = fwd_b_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector tables plus random stimulus against a
// pipeline-occupancy model (who sits in E/M/W) rather than a per-register scoreboard.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hz ();
   pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hz));

   // exp bits: [11]stall_f [10]stall_d [9]stall_e [8]stall_m [7]bubble_e [6]bubble_w
   //           [5]flush_d [4]drop_fetch [3:2]fwd_a [1:0]fwd_b
   typedef struct {
      bit        dv;
      bit [4:0]  ra1, ra2;
      bit        en1, en2;
      bit [4:0]  wa;
      bit        we, ld;
      bit        redir, ipend, iresp, dw;
      bit [11:0] exp;
   } vec_t;

   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       ld;
   } slot_t;

   int    n_checks = 0;
   int    n_errors = 0;
   slot_t pipe [3];           // 0 = E, 1 = M, 2 = W
   bit    m_drain;
   bit [1:0] m_fwd_a, m_fwd_b;
   vec_t  tbl [$];

   function automatic vec_t mk(int dv, int ra1, int en1, int ra2, int en2, int wa,
                               int we, int ld, int ctl, int exp);
      vec_t v;
      v.dv    = (dv != 0);
      v.ra1   = 5'(ra1);
      v.en1   = (en1 != 0);
      v.ra2   = 5'(ra2);
      v.en2   = (en2 != 0);
      v.wa    = 5'(wa);
      v.we    = (we != 0);
      v.ld    = (ld != 0);
      v.redir = ((ctl & 8) != 0);
      v.ipend = ((ctl & 4) != 0);
      v.iresp = ((ctl & 2) != 0);
      v.dw    = ((ctl & 1) != 0);
      v.exp   = 12'(exp);
      return v;
   endfunction

   function automatic logic [11:0] dut_out();
      return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.bubble_e, hz.bubble_w,
              hz.flush_d, hz.drop_fetch, hz.fwd_a, hz.fwd_b};
   endfunction

   task automatic chk(input string name, input logic [11:0] act, input bit [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int s = 0; s < 3; s++) begin
         pipe[s].v  = 1'b0;
         pipe[s].rd = '0;
         pipe[s].ld = 1'b0;
      end
      m_drain = 1'b0;
      m_fwd_a = 2'd0;
      m_fwd_b = 2'd0;
   endfunction

   // Youngest in-flight writer of r: the first occupied stage scanning E, M, W.
   function automatic void lookup(input bit [4:0] r, output bit found, output int stage,
                                  output bit ld);
      found = 1'b0;
      stage = 0;
      ld    = 1'b0;
      if (r != 0) begin
         for (int s = 0; s < 3; s++) begin
            if (!found && pipe[s].v && pipe[s].rd == r) begin
               found = 1'b1;
               stage = s;
               ld    = pipe[s].ld;
            end
         end
      end
   endfunction

   function automatic bit [1:0] fwd_sel(input bit [4:0] r);
      bit found, ld;
      int stage;
      lookup(r, found, stage, ld);
      if (!found) return 2'd0;
      if (stage == 0) return 2'd1;
      if (stage == 1) return 2'd2;
      return 2'd0;
   endfunction

   function automatic bit src_waits_on_load(input bit en, input bit [4:0] r);
      bit found, ld;
      int stage;
      lookup(r, found, stage, ld);
      return en && found && ld && stage == 0;
   endfunction

   function automatic bit [11:0] model_out(input vec_t v);
      bit sf, sd, se, sm, be, bw, fl, dr;
      {sf, sd, se, sm, be, bw, fl, dr} = 8'b0;
      if (m_drain) begin
         fl = 1'b1;
         dr = v.iresp;
      end
      if (v.dw) begin
         {sf, sd, se, sm, bw} = 5'b11111;
      end else if (!m_drain && v.redir) begin
         fl = 1'b1;
         be = 1'b1;
      end else if (!m_drain && v.dv &&
                   (src_waits_on_load(v.en1, v.ra1) || src_waits_on_load(v.en2, v.ra2))) begin
         {sf, sd, be} = 3'b111;
      end
      return {sf, sd, se, sm, be, bw, fl, dr, m_fwd_a, m_fwd_b};
   endfunction

   function automatic void model_step(input vec_t v, input bit [11:0] o);
      bit issue;
      issue = v.dv && !o[10] && !o[5] && !v.dw;
      if (!v.dw) begin
         m_fwd_a = issue ? fwd_sel(v.ra1) : 2'd0;
         m_fwd_b = issue ? fwd_sel(v.ra2) : 2'd0;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0].v  = issue && v.we && v.wa != 0;
         pipe[0].rd = v.wa;
         pipe[0].ld = v.ld;
      end
      if (m_drain) begin
         if (v.iresp) m_drain = 1'b0;
      end else if (!v.dw && v.redir && v.ipend && !v.iresp) begin
         m_drain = 1'b1;
      end
   endfunction

   task automatic drive(input vec_t v);
      hz.d_valid      = v.dv;
      hz.d_ra1        = v.ra1;
      hz.d_ra2        = v.ra2;
      hz.d_ra1En      = v.en1;
      hz.d_ra2En      = v.en2;
      hz.d_wa         = v.wa;
      hz.d_RegWEn     = v.we;
      hz.d_is_load    = v.ld;
      hz.e_redirect   = v.redir;
      hz.ibus_pending = v.ipend;
      hz.ibus_resp    = v.iresp;
      hz.dbus_wait    = v.dw;
   endtask

   // Entered just after a rising edge; leaves just after the next one.
   task automatic apply(input vec_t v, input bit use_const, input string name);
      bit [11:0] m;
      drive(v);
      @(negedge clk);
      m = model_out(v);
      chk({name, "_model"}, dut_out(), m);
      if (use_const) chk(name, dut_out(), v.exp);
      assert (!(m_drain && v.redir)) else $error("stimulus drove e_redirect during drain");
      model_step(v, m);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t r;

      reset = 1'b0;
      model_reset();
      // Reset must dominate even an active dbus_wait/redirect.
      drive(mk(1, 5, 1, 6, 1, 7, 1, 1, 4'b1101, 0));
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", dut_out(), 12'h000);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Load-use, back-to-back forwarding, two writers to x5.
      tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 1, 0, 'h000));  // ld  x5,0(x1)
      tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 'hC80));  // add x6,x5,x1 stalls
      tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 'h000));  // add issues
      tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 0, 0, 'h008));  // addi x5; add got fwd_a=W
      tbl.push_back(mk(1, 5, 1, 5, 1, 7, 1, 0, 0, 'h000));  // sub x7,x5,x5 no stall
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h005));  // sub got fwd_a=fwd_b=M
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000));
      tbl.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 'h000));  // add x5,x1,x2
      tbl.push_back(mk(1, 3, 1, 0, 0, 5, 1, 1, 0, 'h000));  // ld  x5,0(x3)
      tbl.push_back(mk(1, 5, 1, 0, 1, 8, 1, 0, 0, 'hC80));  // consumer: youngest is the load
      tbl.push_back(mk(1, 5, 1, 0, 1, 8, 1, 0, 0, 'h000));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h008));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1, $sformatf("tbl%0d", i));

      // Redirect with the wrong-path response three cycles later.
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 'h0A0), 1'b1, "redir0");
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 'h020), 1'b1, "drain1");
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 'h020), 1'b1, "drain2");
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 'h030), 1'b1, "drain_resp");
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 'h000), 1'b1, "back_to_run");

      // dbus_wait for 5 cycles with the load in M and a consumer at D.
      apply(mk(1, 1, 1, 0, 0, 5, 1, 1, 0, 'h000), 1'b1, "dw_ld");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000), 1'b1, "dw_gap");
      for (int i = 0; i < 5; i++)
         apply(mk(1, 5, 1, 1, 1, 6, 1, 0, 4'b0001, 'hF40), 1'b1, $sformatf("dw_hold%0d", i));
      apply(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 'h000), 1'b1, "dw_release");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h008), 1'b1, "dw_fwd");

      // Reset in the middle of a drain with a load in flight.
      apply(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 'h000), 1'b1, "rst_ld");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 'h0A0), 1'b1, "rst_redir");
      drive(mk(1, 9, 1, 0, 0, 10, 1, 0, 4'b0100, 0));
      #2;
      chk("rst_pre_drain", dut_out(), 12'h020);
      reset = 1'b0;
      #1;
      chk("rst_mid_drain", dut_out(), 12'h000);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      apply(mk(1, 9, 1, 0, 0, 10, 1, 0, 4'b0100, 'h000), 1'b1, "rst_dep");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000), 1'b1, "rst_dep_fwd");

      // Random traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         r.dv    = 1'($urandom_range(0, 3) != 0);
         r.ra1   = 5'($urandom_range(0, 7));
         r.ra2   = 5'($urandom_range(0, 7));
         r.en1   = 1'($urandom_range(0, 1));
         r.en2   = 1'($urandom_range(0, 1));
         r.wa    = 5'($urandom_range(0, 7));
         r.we    = 1'($urandom_range(0, 3) != 0);
         r.ld    = 1'($urandom_range(0, 2) == 0);
         r.redir = !m_drain && ($urandom_range(0, 9) == 0);
         r.ipend = 1'($urandom_range(0, 1));
         r.iresp = 1'($urandom_range(0, 2) == 0);
         r.dw    = 1'($urandom_range(0, 4) == 0);
         r.exp   = '0;
         apply(r, 1'b0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV64I pipeline (F/D/E/M/W).
- Keeps a 32-entry age-tagged scoreboard of in-flight register writers, built from the decoded control bundle at D.
- Detects load-use hazards and drives forwarding selects.
- Sequences branch/JALR redirects, including draining a wrong-path ibus fetch, and freezes the pipeline on dbus wait.

Parameters:
- NREG, 32, architectural registers tracked; x0 is never marked pending.
- AGE_W, 2, width of the stage-age tag (0=E, 1=M, 2=W).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- d_valid  in  1  D holds a valid instruction
- d_ra1, d_ra2  in  5 each  D source registers
- d_ra1En, d_ra2En  in  1 each  source read enables from decoder
- d_wa  in  5  D destination register
- d_RegWEn  in  1  D writes a register
- d_is_load  in  1  D MemRW==2'b10
- e_redirect  in  1  E resolved taken branch/JAL/JALR mispredict
- ibus_pending  in  1  fetch request outstanding, no response yet
- ibus_resp  in  1  fetch response handshake this cycle
- dbus_wait  in  1  M memory access not complete
- stall_f, stall_d  out  1 each  hold F/D registers
- stall_e, stall_m  out  1 each  hold E/M registers
- bubble_e  out  1  insert NOP into E
- bubble_w  out  1  insert NOP into W
- flush_d  out  1  kill D contents
- drop_fetch  out  1  discard the current ibus response
- fwd_a, fwd_b  out  2 each  forwarding select for E operands: 0=regfile, 1=from M, 2=from W

Behaviour:
- Reset (async, reset==0):
  - Scoreboard cleared; FSM enters RUN.
  - All outputs 0.
- Scoreboard entry r holds {valid, is_load, age}.
- Definitions:
  - adv = !dbus_wait.
  - issue = d_valid & !stall_d & !flush_d & adv.
- Aging, each cycle with adv:
  - Every valid entry's age increments.
  - An entry whose age was 2 is cleared.
  - Then, if issue & d_RegWEn & d_wa!=0, entry[d_wa] is set to {1, d_is_load, 0}. This overwrites any older writer, so the youngest writer wins.
  - Without adv, the scoreboard holds.
- Redirect kill: when flush_d is asserted, no entry is created for D.
- Load-use:
  - luse = d_valid & ((d_ra1En & d_ra1!=0 & sb[d_ra1].valid & sb[d_ra1].is_load & age==0), or the same test for ra2).
  - luse gives stall_f=stall_d=1 and bubble_e=1 for exactly one cycle, since the load ages to M next cycle.
- Forwarding: fwd_a/fwd_b are registered at issue from the scoreboard age of the source.
  - Age 0 at issue gives 1 (from M).
  - Age 1 gives 2 (from W).
  - Otherwise 0.
  - x0 always gives 0.
- dbus_wait:
  - Asserts stall_f, stall_d, stall_e, stall_m and bubble_w combinationally, same cycle.
  - Scoreboard frozen.
  - Overrides redirect handling: e_redirect is sampled only when dbus_wait==0.
- Redirect FSM states: RUN, DRAIN.
  - RUN & e_redirect & adv:
    - flush_d=1 and bubble_e=1 this cycle; luse is ignored.
    - If ibus_pending & !ibus_resp, next state is DRAIN; otherwise stay in RUN.
  - DRAIN:
    - stall_f=0; drop_fetch = ibus_resp.
    - On ibus_resp, go to RUN.
    - flush_d=1 for each DRAIN cycle.
  - e_redirect during DRAIN is impossible (E holds a bubble); the bench asserts it never happens.
- Priority: reset > dbus_wait > redirect > load-use.
- Latency: all stall/flush outputs are combinational from inputs and current state; scoreboard and FSM update on posedge.
- Reset deasserted mid-operation: the pipeline restarts from an empty scoreboard; no stale forwarding.

Decomposition:
- Shared pipes package: typedef sb_entry_t {valid, is_load, age}; enum hz_state_t {HZ_RUN, HZ_DRAIN}; enum fwd_sel_t {FWD_RF, FWD_M, FWD_W}.
- Sub-module hazard_scoreboard: storage, aging and lookup ports.
- pipe_hazard_ctrl holds the FSM and priority logic.

Test Plan:
- ld x5 at D, next cycle add x6,x5,x1 → one cycle of stall_d=1 and bubble_e=1; add issues with fwd_a=2 (W).
- addi x5 then sub x7,x5,x5 back-to-back → no stall; fwd_a=fwd_b=1.
- e_redirect with ibus_pending=1 and resp 3 cycles later → flush_d in 4 consecutive cycles; drop_fetch=1 only in the resp cycle; then RUN.
- dbus_wait=1 for 5 cycles while ld x5 is at M and a dependent instruction is at D → all stalls=1 and bubble_w=1; scoreboard ages unchanged; no load-use bubble after release.
- Two writers to x5 (add then ld) in flight, consumer at D → the youngest (load) governs: stall_d=1.
- reset asserted mid-DRAIN with a pending load → all outputs 0 immediately; dependent instruction after reset issues with fwd=0 and no stall.
